// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multicycle control path: opcodes, FSM states,
// ALU operation codes and the decoded control word.
package cpu_defs_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
    localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
    localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
    localparam logic [OP_W-1:0] OP_SLT  = 6'b100111;
    localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OP_W-1:0] OP_J    = 6'b111000;
    localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;
    localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_L   = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    typedef struct packed {
        logic               pc_wre;
        logic               ir_wre;
        logic               ins_mem_rw;
        logic               ext_sel;
        logic               alu_src_b;
        logic               alu_m2reg;
        logic               reg_wre;
        logic               wr_reg_data;
        logic               data_mem_rw;
        logic               data_mem_en;
        logic [1:0]         reg_out;
        logic [1:0]         pc_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_word_t;

    // Register-register ALU instructions (write rd)
    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
    endfunction

    // Instructions that finish in ID by redirecting the PC
    function automatic logic is_jump(input logic [OP_W-1:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word decode from current state and opcode.
// Ports: state_i (FSM state), op_i (opcode), zero_i (ALU zero flag),
//        mem_ready_i (data-memory done), ctrl_o (decoded control word).
module ctrl_decode
    import cpu_defs_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output ctrl_word_t      ctrl_o
);

    always_comb begin
        ctrl_o             = '0;
        ctrl_o.ext_sel     = 1'b1;
        ctrl_o.wr_reg_data = 1'b1;
        ctrl_o.alu_op      = ALU_ADD;

        // Datapath steering depends only on the opcode
        if (op_i == OP_ORI) ctrl_o.ext_sel = 1'b0;
        if ((op_i == OP_ADDI) || (op_i == OP_ORI) || (op_i == OP_LW) || (op_i == OP_SW))
            ctrl_o.alu_src_b = 1'b1;

        if (is_rtype(op_i))
            ctrl_o.reg_out = 2'b10;
        else if ((op_i == OP_ADDI) || (op_i == OP_ORI) || (op_i == OP_LW))
            ctrl_o.reg_out = 2'b01;

        case (op_i)
            OP_SUB, OP_BEQ: ctrl_o.alu_op = ALU_SUB;
            OP_SLL:         ctrl_o.alu_op = ALU_SLL;
            OP_OR, OP_ORI:  ctrl_o.alu_op = ALU_OR;
            OP_AND:         ctrl_o.alu_op = ALU_AND;
            OP_SLT:         ctrl_o.alu_op = ALU_SLT;
            default:        ctrl_o.alu_op = ALU_ADD;
        endcase

        // Strobes are state-qualified
        case (state_i)
            S_IF: begin
                ctrl_o.ir_wre     = 1'b1;
                ctrl_o.ins_mem_rw = 1'b1;
            end
            S_ID: begin
                if (is_jump(op_i)) begin
                    ctrl_o.pc_wre = 1'b1;
                    ctrl_o.pc_src = (op_i == OP_JR) ? 2'b10 : 2'b11;
                end
                if (op_i == OP_JAL) begin
                    ctrl_o.reg_wre     = 1'b1;
                    ctrl_o.reg_out     = 2'b00;
                    ctrl_o.wr_reg_data = 1'b0;
                end
            end
            S_EXE_BR: begin
                ctrl_o.pc_wre = 1'b1;
                ctrl_o.pc_src = zero_i ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                ctrl_o.data_mem_en = 1'b1;
                if (op_i == OP_SW) begin
                    ctrl_o.data_mem_rw = 1'b1;
                    ctrl_o.pc_wre      = mem_ready_i;
                end
            end
            S_WB_AL: begin
                ctrl_o.pc_wre  = 1'b1;
                ctrl_o.reg_wre = 1'b1;
            end
            S_WB_L: begin
                ctrl_o.pc_wre    = 1'b1;
                ctrl_o.reg_wre   = 1'b1;
                ctrl_o.alu_m2reg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: state register, retire counter and halt/illegal
// status; control outputs come from ctrl_decode.
// Ports: CLK/RST (async active-low), Opcode, Zero, MemReady in; control
//        strobes, State, Halted, Illegal, RetireCnt out.
module multicycle_control
    import cpu_defs_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    input  logic           MemReady,
    output logic           PCWre,
    output logic           IRWre,
    output logic           InsMemRW,
    output logic           ExtSel,
    output logic           ALUSrcB,
    output logic           ALUM2Reg,
    output logic           RegWre,
    output logic           WrRegData,
    output logic           DataMemRW,
    output logic           DataMemEn,
    output logic [1:0]     RegOut,
    output logic [1:0]     PCSrc,
    output logic [2:0]     ALUOp,
    output logic [3:0]     State,
    output logic           Halted,
    output logic           Illegal,
    output logic [31:0]    RetireCnt
);

    localparam int unsigned CNT_W = 32;

    state_e            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic              halted_q;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic [OP_W-1:0]   op;
    ctrl_word_t        ctrl;

    assign op = OP_W'(Opcode);

    // State register and status
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            halted_q  <= (state_d == S_HALT);
            retire_q  <= retire_d;
        end
    end

    // Next-state and retire accounting
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_jump(op))                     state_d = S_IF;
                else if (op == OP_HALT)              state_d = S_HALT;
                else if (op == OP_BEQ)               state_d = S_EXE_BR;
                else if ((op == OP_LW) || (op == OP_SW)) state_d = S_EXE_LS;
                else if (is_rtype(op) || (op == OP_ADDI) || (op == OP_ORI))
                                                     state_d = S_EXE_AL;
                else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                if (MemReady) state_d = (op == OP_SW) ? S_IF : S_WB_L;
            end
            S_WB_L:   state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
        // Every return to IF retires one instruction; counter wraps naturally
        retire_d = retire_q + CNT_W'((state_q != S_IF) && (state_d == S_IF));
    end

    ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op),
        .zero_i      (Zero),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl)
    );

    assign PCWre     = ctrl.pc_wre;
    assign IRWre     = ctrl.ir_wre;
    assign InsMemRW  = ctrl.ins_mem_rw;
    assign ExtSel    = ctrl.ext_sel;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUM2Reg  = ctrl.alu_m2reg;
    assign RegWre    = ctrl.reg_wre;
    assign WrRegData = ctrl.wr_reg_data;
    assign DataMemRW = ctrl.data_mem_rw;
    assign DataMemEn = ctrl.data_mem_en;
    assign RegOut    = ctrl.reg_out;
    assign PCSrc     = ctrl.pc_src;
    assign ALUOp     = ctrl.alu_op;
    assign State     = state_q;
    assign Halted    = halted_q;
    assign Illegal   = illegal_q;
    assign RetireCnt = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        MemReady;
    logic        PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUM2Reg;
    logic        RegWre, WrRegData, DataMemRW, DataMemEn;
    logic [1:0]  RegOut, PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  State;
    logic        Halted, Illegal;
    logic [31:0] RetireCnt;

    int errors = 0;
    int checks = 0;

    multicycle_control #(.OPW(6)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
        .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg), .RegWre(RegWre),
        .WrRegData(WrRegData), .DataMemRW(DataMemRW), .DataMemEn(DataMemEn),
        .RegOut(RegOut), .PCSrc(PCSrc), .ALUOp(ALUOp), .State(State),
        .Halted(Halted), .Illegal(Illegal), .RetireCnt(RetireCnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b0; Opcode = 6'b000000; Zero = 1'b0; MemReady = 1'b0;
        #3;
        chk("rst_state",   32'(State),     32'h0);
        chk("rst_retire",  RetireCnt,      32'h0);
        chk("rst_halted",  32'(Halted),    32'h0);
        chk("rst_illegal", 32'(Illegal),   32'h0);
        #9 RST = 1'b1;   // released between edges

        // add: IF, ID, EXE_AL, WB_AL, IF
        chk("add_if_state", 32'(State),    32'h0);
        chk("add_if_irwre", 32'(IRWre),    32'h1);
        chk("add_if_insrw", 32'(InsMemRW), 32'h1);
        chk("add_if_regwr", 32'(RegWre),   32'h0);
        tick();
        chk("add_id_state", 32'(State),    32'h1);
        chk("add_id_irwre", 32'(IRWre),    32'h0);
        chk("add_id_regwr", 32'(RegWre),   32'h0);
        tick();
        chk("add_ex_state", 32'(State),    32'h6);
        chk("add_ex_regwr", 32'(RegWre),   32'h0);
        chk("add_ex_aluop", 32'(ALUOp),    32'h0);
        tick();
        chk("add_wb_state", 32'(State),    32'h7);
        chk("add_wb_regwr", 32'(RegWre),   32'h1);
        chk("add_wb_regout",32'(RegOut),   32'h2);
        chk("add_wb_pcwre", 32'(PCWre),    32'h1);
        tick();
        chk("add_done_state",  32'(State), 32'h0);
        chk("add_done_retire", RetireCnt,  32'd1);

        // beq taken
        Opcode = 6'b110100;
        tick();
        chk("beq1_id_state", 32'(State), 32'h1);
        tick();
        Zero = 1'b1; #1;
        chk("beq1_br_state", 32'(State), 32'h5);
        chk("beq1_pcsrc",    32'(PCSrc), 32'h1);
        chk("beq1_pcwre",    32'(PCWre), 32'h1);
        chk("beq1_aluop",    32'(ALUOp), 32'h1);
        tick();
        chk("beq1_done_state",  32'(State), 32'h0);
        chk("beq1_done_retire", RetireCnt,  32'd2);

        // beq not taken
        tick();
        tick();
        Zero = 1'b0; #1;
        chk("beq0_br_state", 32'(State), 32'h5);
        chk("beq0_pcsrc",    32'(PCSrc), 32'h0);
        tick();
        chk("beq0_done_state",  32'(State), 32'h0);
        chk("beq0_done_retire", RetireCnt,  32'd3);

        // lw with three not-ready MEM cycles
        Opcode = 6'b110001; MemReady = 1'b0;
        tick();
        tick();
        chk("lw_exls_state", 32'(State),   32'h2);
        chk("lw_exls_srcb",  32'(ALUSrcB), 32'h1);
        tick();
        chk("lw_mem1_state", 32'(State),     32'h3);
        chk("lw_mem1_en",    32'(DataMemEn), 32'h1);
        chk("lw_mem1_rw",    32'(DataMemRW), 32'h0);
        chk("lw_mem1_pcwre", 32'(PCWre),     32'h0);
        tick();
        chk("lw_mem2_state", 32'(State), 32'h3);
        tick();
        chk("lw_mem3_state", 32'(State), 32'h3);
        tick();
        chk("lw_mem4_state", 32'(State), 32'h3);
        MemReady = 1'b1; #1;
        chk("lw_mem4_pcwre", 32'(PCWre), 32'h0);
        tick();
        MemReady = 1'b0;
        chk("lw_wbl_state",  32'(State),    32'h4);
        chk("lw_wbl_m2reg",  32'(ALUM2Reg), 32'h1);
        chk("lw_wbl_regwr",  32'(RegWre),   32'h1);
        chk("lw_wbl_regout", 32'(RegOut),   32'h1);
        tick();
        chk("lw_done_retire", RetireCnt, 32'd4);

        // jal
        Opcode = 6'b111010;
        tick();
        chk("jal_id_state",  32'(State),     32'h1);
        chk("jal_regwr",     32'(RegWre),    32'h1);
        chk("jal_regout",    32'(RegOut),    32'h0);
        chk("jal_wrdata",    32'(WrRegData), 32'h0);
        chk("jal_pcsrc",     32'(PCSrc),     32'h3);
        chk("jal_pcwre",     32'(PCWre),     32'h1);
        tick();
        chk("jal_done_state",  32'(State), 32'h0);
        chk("jal_done_retire", RetireCnt,  32'd5);

        // jr
        Opcode = 6'b111001;
        tick();
        chk("jr_pcsrc", 32'(PCSrc),  32'h2);
        chk("jr_pcwre", 32'(PCWre),  32'h1);
        chk("jr_regwr", 32'(RegWre), 32'h0);
        tick();
        chk("jr_done_retire", RetireCnt, 32'd6);

        // ori: zero-extend, immediate operand, writes rt
        Opcode = 6'b010010;
        tick();
        tick();
        chk("ori_ex_state",  32'(State),   32'h6);
        chk("ori_extsel",    32'(ExtSel),  32'h0);
        chk("ori_aluop",     32'(ALUOp),   32'h3);
        chk("ori_srcb",      32'(ALUSrcB), 32'h1);
        tick();
        chk("ori_wb_regout", 32'(RegOut),  32'h1);
        tick();
        chk("ori_done_retire", RetireCnt, 32'd7);

        // sw aborted by reset during MEM
        Opcode = 6'b110000; MemReady = 1'b0;
        tick();
        tick();
        tick();
        chk("sw_mem_state", 32'(State),     32'h3);
        chk("sw_mem_rw",    32'(DataMemRW), 32'h1);
        chk("sw_mem_pcwre", 32'(PCWre),     32'h0);
        MemReady = 1'b1; #1;
        chk("sw_ready_pcwre", 32'(PCWre), 32'h1);
        MemReady = 1'b0;
        RST = 1'b0; #1;
        chk("sw_rst_state",  32'(State),     32'h0);
        chk("sw_rst_memen",  32'(DataMemEn), 32'h0);
        chk("sw_rst_retire", RetireCnt,      32'h0);
        chk("sw_rst_pcwre",  32'(PCWre),     32'h0);
        RST = 1'b1;

        // illegal opcode
        Opcode = 6'b101010;
        tick();
        chk("ill_id_state",   32'(State),   32'h1);
        chk("ill_id_illegal", 32'(Illegal), 32'h0);
        tick();
        chk("ill_state",   32'(State),   32'h8);
        chk("ill_illegal", 32'(Illegal), 32'h1);
        chk("ill_halted",  32'(Halted),  32'h1);
        for (int i = 0; i < 10; i++) begin
            Zero = i[0]; MemReady = i[1];
            tick();
            chk("ill_hold_pcwre", 32'(PCWre), 32'h0);
            chk("ill_hold_state", 32'(State), 32'h8);
        end
        chk("ill_retire", RetireCnt, 32'h0);

        // reset clears halt, then halt opcode is legal
        RST = 1'b0; #1;
        chk("rst2_illegal", 32'(Illegal), 32'h0);
        chk("rst2_halted",  32'(Halted),  32'h0);
        RST = 1'b1;
        Opcode = 6'b111111;
        tick();
        tick();
        chk("halt_state",   32'(State),   32'h8);
        chk("halt_halted",  32'(Halted),  32'h1);
        chk("halt_illegal", 32'(Illegal), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the parameter OPW, default 6, giving the opcode width.
REQ-002 Port CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port RST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port Opcode  in  6  SHALL be the opcode held in the instruction register.
REQ-005 Port Zero  in  1  SHALL be the ALU zero flag.
REQ-006 Port MemReady  in  1  SHALL be the data-memory done handshake, sampled only in MEM.
REQ-007 Outputs, all 1 bit unless stated, SHALL be: PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUM2Reg, RegWre, WrRegData, DataMemRW, DataMemEn, RegOut[1:0], PCSrc[1:0], ALUOp[2:0], State[3:0], Halted, Illegal, RetireCnt[31:0].

Function
REQ-008 Opcodes SHALL be fixed as follows: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100111, sw 110000, lw 110001, beq 110100, j 111000, jal 111010, jr 111001, halt 111111.
REQ-009 State codes SHALL be: IF 0000, ID 0001, EXE_AL 0110, WB_AL 0111, EXE_LS 0010, MEM 0011, WB_L 0100, EXE_BR 0101, HALT 1000.
REQ-010 Transitions SHALL be:
- IF -> ID.
- ID -> j/jal/jr: IF; halt: HALT; beq: EXE_BR; lw/sw: EXE_LS; arithmetic/logic: EXE_AL; undefined opcode: HALT with Illegal=1.
- EXE_AL -> WB_AL -> IF.
- EXE_BR -> IF.
- EXE_LS -> MEM.
- MEM -> stays in MEM while MemReady=0; when MemReady=1, sw -> IF and lw -> WB_L.
- WB_L -> IF.
- HALT is absorbing until reset.
REQ-011 IRWre and InsMemRW=1 SHALL be asserted only in IF; IRWre=0 in every other state.
REQ-012 PCWre SHALL be 1 in:
- IF-exit states: WB_AL, EXE_BR, WB_L.
- MEM, when sw and MemReady=1.
- ID, for j/jal/jr.
PCWre SHALL be 0 otherwise and always 0 in HALT.
REQ-013 PCSrc SHALL be:
- 00 (PC+4) by default;
- 01 in EXE_BR when Zero=1;
- 10 for jr;
- 11 for j/jal.
REQ-014 RegWre SHALL be 1 only in:
- WB_AL;
- WB_L;
- ID, for jal, with RegOut=00 (r31) and WrRegData=0 (PC+4).
RegOut SHALL be 10 (rd) for R-type and 01 (rt) for addi/ori/lw.
REQ-015 DataMemEn SHALL be 1 only in MEM.
REQ-016 DataMemRW SHALL be 1 in MEM only for sw.
REQ-017 ALUM2Reg SHALL be 1 in WB_L.
REQ-018 ALUSrcB SHALL be 1 for addi, ori, lw and sw.
REQ-019 ExtSel SHALL be 0 for ori and 1 otherwise.
REQ-020 ALUOp SHALL be:
- add/addi/lw/sw 000
- sub/beq 001
- sll 010
- or/ori 011
- and 100
- slt 101
REQ-021 All control outputs SHALL be combinational decodes of State and Opcode, plus Zero/MemReady where stated.
REQ-022 State, Halted, Illegal and RetireCnt SHALL be registered.
REQ-023 RetireCnt SHALL increment by 1 on every edge that leaves a state for IF; it wraps 0xFFFFFFFF -> 0.
REQ-024 Halted SHALL be 1 exactly while State=HALT.
REQ-025 Opcode SHALL be decoded in ID and in later states; it is don't-care in IF.

Reset
REQ-026 While RST=0, State SHALL be IF, RetireCnt 0, and Halted and Illegal 0, immediately and independently of CLK.
REQ-027 Reset asserted mid-instruction (including a MEM wait) SHALL abort it with no further PCWre, RegWre or DataMemEn.
REQ-028 On RST release, the first rising edge SHALL perform IF -> ID.

Structure
REQ-029 Opcode, state and ALUOp encodings SHALL live in the shared package cpu_defs_pkg.
REQ-030 One sub-module, ctrl_decode (combinational Opcode+State -> control word), SHALL be used; the state register and counter remain in the top.

Verification
REQ-031 add (000000) from reset: State SHALL go 0000,0001,0110,0111,0000; RegWre=1 only in cycle 4 with RegOut=10; RetireCnt=1.
REQ-032 beq with Zero=1 in EXE_BR: PCSrc=01 and PCWre=1; with Zero=0: PCSrc=00; each takes 3 cycles.
REQ-033 lw with MemReady held 0 for 3 cycles: State SHALL hold 0011 for 4 cycles with DataMemEn=1 and DataMemRW=0, then 0100 with ALUM2Reg=1 and RegWre=1.
REQ-034 Opcode 101010 in ID: State SHALL become 1000 with Illegal=1 and Halted=1; PCWre SHALL stay 0 for 10 further cycles.
REQ-035 RST pulsed low while in MEM (sw): State SHALL be 0000 asynchronously, DataMemEn=0, RetireCnt=0.
REQ-036 jal: State SHALL go IF, ID, IF; in ID RegWre=1, RegOut=00, PCSrc=11 and PCWre=1.
